// File: rtl/vga_timing_controller.sv
// VGA sync generator: horizontal/vertical FSMs, count_en gating and frame-aligned run/stop.
// Optional SYNC_NEG_POL_EN: hsync/vsync active-low (idle and reset high).
module vga_timing_controller #(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 40,
   parameter int H_SYNC   = 128,
   parameter int H_BP     = 88,
   parameter int V_ACTIVE = 600,
   parameter int V_FP     = 1,
   parameter int V_SYNC   = 4,
   parameter int V_BP     = 23
) (
   input  logic CLK_40,
   input  logic reset_n,
   input  logic clk_en,
   input  logic run,
   output logic hsync,
   output logic vsync,
   output logic count_en,
   output logic line_start,
   output logic frame_start,
   output logic frame_done,
   output logic busy
);

   localparam int H_M0  = (H_ACTIVE > H_FP) ? H_ACTIVE : H_FP;
   localparam int H_M1  = (H_SYNC > H_BP) ? H_SYNC : H_BP;
   localparam int H_MAX = (H_M0 > H_M1) ? H_M0 : H_M1;
   localparam int V_M0  = (V_ACTIVE > V_FP) ? V_ACTIVE : V_FP;
   localparam int V_M1  = (V_SYNC > V_BP) ? V_SYNC : V_BP;
   localparam int V_MAX = (V_M0 > V_M1) ? V_M0 : V_M1;
   localparam int HW    = (H_MAX > 1) ? $clog2(H_MAX) : 1;
   localparam int VW    = (V_MAX > 1) ? $clog2(V_MAX) : 1;

`ifdef SYNC_NEG_POL_EN
   localparam logic SYNC_IDLE = 1'b1;
`else
   localparam logic SYNC_IDLE = 1'b0;
`endif

   typedef enum logic [2:0] {HS_IDLE, HS_ACT, HS_FP, HS_SYN, HS_BP} h_state_e;
   typedef enum logic [2:0] {VS_IDLE, VS_ACT, VS_FP, VS_SYN, VS_BP} v_state_e;

   h_state_e        h_state_q, h_state_d;
   v_state_e        v_state_q, v_state_d;
   logic [HW-1:0]   h_cnt_q, h_cnt_d;
   logic [VW-1:0]   v_cnt_q, v_cnt_d;
   logic            h_last, v_last, line_end, frame_end;
   logic            hsync_d, vsync_d, count_en_d, line_start_d, frame_start_d, frame_done_d, busy_d;

   always_comb begin
      h_last = 1'b0;
      case (h_state_q)
         HS_ACT:  h_last = (h_cnt_q == HW'(H_ACTIVE - 1));
         HS_FP:   h_last = (h_cnt_q == HW'(H_FP - 1));
         HS_SYN:  h_last = (h_cnt_q == HW'(H_SYNC - 1));
         HS_BP:   h_last = (h_cnt_q == HW'(H_BP - 1));
         default: h_last = 1'b0;
      endcase
   end

   always_comb begin
      v_last = 1'b0;
      case (v_state_q)
         VS_ACT:  v_last = (v_cnt_q == VW'(V_ACTIVE - 1));
         VS_FP:   v_last = (v_cnt_q == VW'(V_FP - 1));
         VS_SYN:  v_last = (v_cnt_q == VW'(V_SYNC - 1));
         VS_BP:   v_last = (v_cnt_q == VW'(V_BP - 1));
         default: v_last = 1'b0;
      endcase
   end

   assign line_end  = clk_en && (h_state_q == HS_BP) && h_last;
   assign frame_end = line_end && (v_state_q == VS_BP) && v_last;

   always_comb begin
      h_state_d = h_state_q;
      h_cnt_d   = h_cnt_q;
      if (clk_en) begin
         if (h_state_q == HS_IDLE) begin
            if (run) h_state_d = HS_ACT;
            h_cnt_d = '0;
         end else if (h_last) begin
            h_cnt_d = '0;
            case (h_state_q)
               HS_ACT:  h_state_d = HS_FP;
               HS_FP:   h_state_d = HS_SYN;
               HS_SYN:  h_state_d = HS_BP;
               HS_BP:   h_state_d = (frame_end && !run) ? HS_IDLE : HS_ACT;
               default: h_state_d = HS_IDLE;
            endcase
         end else begin
            h_cnt_d = h_cnt_q + 1'b1;
         end
      end
   end

   // Vertical timing steps once per completed line; run only matters at the frame boundary.
   always_comb begin
      v_state_d = v_state_q;
      v_cnt_d   = v_cnt_q;
      if (v_state_q == VS_IDLE) begin
         if (clk_en && run) v_state_d = VS_ACT;
         v_cnt_d = '0;
      end else if (line_end) begin
         if (v_last) begin
            v_cnt_d = '0;
            case (v_state_q)
               VS_ACT:  v_state_d = VS_FP;
               VS_FP:   v_state_d = VS_SYN;
               VS_SYN:  v_state_d = VS_BP;
               VS_BP:   v_state_d = run ? VS_ACT : VS_IDLE;
               default: v_state_d = VS_IDLE;
            endcase
         end else begin
            v_cnt_d = v_cnt_q + 1'b1;
         end
      end
   end

   // Outputs describe the state being entered; pulses need a tick so they never stretch.
   always_comb begin
      hsync_d       = (h_state_d == HS_SYN) ^ SYNC_IDLE;
      vsync_d       = (v_state_d == VS_SYN) ^ SYNC_IDLE;
      count_en_d    = (h_state_d == HS_ACT) && (v_state_d == VS_ACT);
      line_start_d  = clk_en && count_en_d && (h_cnt_d == '0);
      frame_start_d = line_start_d && (v_cnt_d == '0);
      frame_done_d  = clk_en && (h_state_d == HS_BP) && (h_cnt_d == HW'(H_BP - 1)) &&
                      (v_state_d == VS_BP) && (v_cnt_d == VW'(V_BP - 1));
      busy_d        = (h_state_d != HS_IDLE);
   end

   always_ff @(posedge CLK_40) begin
      if (!reset_n) begin
         h_state_q   <= HS_IDLE;
         v_state_q   <= VS_IDLE;
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         hsync       <= SYNC_IDLE;
         vsync       <= SYNC_IDLE;
         count_en    <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         busy        <= 1'b0;
      end else begin
         h_state_q   <= h_state_d;
         v_state_q   <= v_state_d;
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         hsync       <= hsync_d;
         vsync       <= vsync_d;
         count_en    <= count_en_d;
         line_start  <= line_start_d;
         frame_start <= frame_start_d;
         frame_done  <= frame_done_d;
         busy        <= busy_d;
      end
   end

endmodule
